// File: rtl/board_button_debouncer.sv
// Board push-button conditioner: 2-flop synchroniser and stability counter per button.
// Define BUTTON_DEBOUNCE_EDGE_EN to build the one-cycle press/release pulse registers.
module board_button_debouncer #(
  parameter int BUTTON_COUNT    = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [BUTTON_COUNT-1:0] button_raw,
  output logic [BUTTON_COUNT-1:0] button_level,
  output logic [BUTTON_COUNT-1:0] button_press,
  output logic [BUTTON_COUNT-1:0] button_release
);
  // state    | meaning
  // STABLE   | cnt is 0; synchronised input agrees with level
  // COUNTING | input disagrees with level; cnt consecutive disagreeing cycles seen

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  logic [BUTTON_COUNT-1:0] sync1_q;
  logic [BUTTON_COUNT-1:0] sync2_q;
  logic [BUTTON_COUNT-1:0] level_q;
  logic [BUTTON_COUNT-1:0] level_d;
  logic [BUTTON_COUNT-1:0] toggle;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
    end
  end

  assign level_d      = level_q ^ toggle;
  assign button_level = level_q;

  for (genvar i = 0; i < BUTTON_COUNT; i++) begin : g_btn
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             toggle_b;

    assign differ    = sync2_q[i] ^ level_q[i];
    assign toggle[i] = toggle_b;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        STABLE:   if (differ && (DEBOUNCE_CYCLES > 1)) state_d = COUNTING;
        COUNTING: if (!differ || (cnt_q == CNT_LAST)) state_d = STABLE;
        default:  state_d = STABLE;
      endcase
    end

    // A single agreeing cycle drops the count back to zero so the full window restarts.
    always_comb begin
      cnt_d    = cnt_q;
      toggle_b = 1'b0;
      case (state_q)
        STABLE: begin
          if (differ) begin
            if (DEBOUNCE_CYCLES == 1) toggle_b = 1'b1;
            else                      cnt_d    = CNT_ONE;
          end
        end
        COUNTING: begin
          if (!differ) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            toggle_b = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCE_EDGE_EN
  logic [BUTTON_COUNT-1:0] press_q;
  logic [BUTTON_COUNT-1:0] release_q;

  // Pulses load on the same edge as the level toggle so they coincide with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= toggle & ~level_q;
      release_q <= toggle & level_q;
    end
  end

  assign button_press   = press_q;
  assign button_release = release_q;
`else
  assign button_press   = '0;
  assign button_release = '0;
`endif

endmodule

// File: tb/tb_board_button_debouncer.sv
// Scoreboard bench for board_button_debouncer: reference model pushes expected outputs
// each edge, an independent monitor pops and compares; directed scenarios plus random bursts.
module tb_board_button_debouncer;
  localparam int N = 2;
  localparam int D = 8;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic         clock      = 1'b0;
  logic         reset_n    = 1'b0;
  logic [N-1:0] button_raw = '0;
  logic [N-1:0] button_level;
  logic [N-1:0] button_press;
  logic [N-1:0] button_release;

  always #5 clock = ~clock;

  board_button_debouncer #(
    .BUTTON_COUNT    (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .button_raw     (button_raw),
    .button_level   (button_level),
    .button_press   (button_press),
    .button_release (button_release)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } exp_t;

  exp_t exp_q[$];

  // Reference: raw reaches the filter two edges late; a level flips once the filter
  // has seen D consecutive samples disagreeing with it.
  logic [N-1:0] m_s1  = '0;
  logic [N-1:0] m_s2  = '0;
  logic [N-1:0] m_lvl = '0;
  int           m_run [N];

  always @(posedge clock or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      exp_q.delete();
    end else begin
      e = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_lvl[i]) m_run[i]++;
        else                     m_run[i] = 0;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) e.prs[i] = EDGE_EN;
          else          e.rel[i] = EDGE_EN;
        end
      end
      m_s2  = m_s1;
      m_s1  = button_raw;
      e.lvl = m_lvl;
      exp_q.push_back(e);
    end
  end

  int prs_cnt [N];
  int rel_cnt [N];

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!reset_n) begin
      check("reset_outputs", {button_level, button_press, button_release}, '0);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_level",   button_level,   e.lvl);
      check("sb_press",   button_press,   e.prs);
      check("sb_release", button_release, e.rel);
    end
    for (int i = 0; i < N; i++) begin
      prs_cnt[i] += int'(button_press[i]);
      rel_cnt[i] += int'(button_release[i]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_for(input logic [N-1:0] want, input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(posedge clock);
      #1;
      edges++;
      if (button_level == want) return;
    end
    edges = -1;
  endtask

  initial begin
    int e;
    int p0, p1, r0, r1;
    for (int i = 0; i < N; i++) begin
      prs_cnt[i] = 0;
      rel_cnt[i] = 0;
    end

    reset_n = 1'b0;
    button_raw = '0;
    cyc(5);
    reset_n = 1'b1;
    cyc(50);
    check("idle_level", button_level, '0);
    check("idle_pulses", prs_cnt[0] + prs_cnt[1] + rel_cnt[0] + rel_cnt[1], 0);

    // Single clean rise on button 0
    p0 = prs_cnt[0];
    button_raw[0] = 1'b1;
    wait_for(2'b01, 30, e);
    check("rise_latency", e, D + 2);
    check("rise_press", button_press, {1'b0, EDGE_EN});
    cyc(5);
    check("rise_press_once", prs_cnt[0] - p0, EDGE_EN);
    check("rise_btn1_quiet", prs_cnt[1] + rel_cnt[1], 0);

    // Bounce then settle
    button_raw[0] = 1'b0;
    cyc(20);
    check("release_level", button_level[0], 1'b0);
    p0 = prs_cnt[0];
    for (int k = 0; k < 40; k++) begin
      button_raw[0] = ((k / 3) % 2) == 0;
      cyc(1);
    end
    check("bounce_level", button_level[0], 1'b0);
    check("bounce_no_press", prs_cnt[0] - p0, 0);
    button_raw[0] = 1'b1;
    wait_for(2'b01, 30, e);
    check("settle_latency", e, D + 2);
    cyc(5);
    check("settle_press_once", prs_cnt[0] - p0, EDGE_EN);

    // Short glitch then accepted pulse on button 1
    p1 = prs_cnt[1];
    r1 = rel_cnt[1];
    button_raw[1] = 1'b1;
    cyc(D - 1);
    button_raw[1] = 1'b0;
    cyc(20);
    check("glitch_level", button_level[1], 1'b0);
    check("glitch_no_pulse", (prs_cnt[1] - p1) + (rel_cnt[1] - r1), 0);
    button_raw[1] = 1'b1;
    cyc(10);
    button_raw[1] = 1'b0;
    cyc(25);
    check("pulse10_press", prs_cnt[1] - p1, EDGE_EN);
    check("pulse10_release", rel_cnt[1] - r1, EDGE_EN);
    check("pulse10_level", button_level[1], 1'b0);

    // Simultaneous rise
    button_raw = '0;
    cyc(20);
    button_raw = '1;
    wait_for(2'b11, 30, e);
    check("both_latency", e, D + 2);
    check("both_press", button_press, {EDGE_EN, EDGE_EN});

    // Reset in the middle of a release count
    cyc(1);
    r0 = rel_cnt[0];
    r1 = rel_cnt[1];
    button_raw = '0;
    cyc(5);
    reset_n = 1'b0;
    #1;
    check("async_reset_level", button_level, '0);
    check("async_reset_pulses", {button_press, button_release}, '0);
    button_raw = '1;
    cyc(3);
    reset_n = 1'b1;
    wait_for(2'b11, 30, e);
    check("post_reset_latency", e, D + 2);
    check("post_reset_press", button_press, {EDGE_EN, EDGE_EN});
    check("reset_no_release", (rel_cnt[0] - r0) + (rel_cnt[1] - r1), 0);

    // Random bursts checked by the scoreboard
    cyc(1);
    for (int s = 0; s < 80; s++) begin
      button_raw = N'($urandom);
      cyc($urandom_range(1, 14));
    end
    cyc(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
